// File: rtl/datapath_pkg.sv
// Shared widths and ALU operation codes for the single-bus datapath.
// Optional mul/div hardware is controlled by DATAPATH_MULDIV_EN.
package datapath_pkg;

  localparam int WORD_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int Z_W      = 2 * WORD_W;
  localparam int CODE_W   = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [Z_W-1:0]    dword_t;
  typedef logic [CODE_W-1:0] alucode_t;

  localparam alucode_t ALU_ADD  = 5'b00011;
  localparam alucode_t ALU_SUB  = 5'b00100;
  localparam alucode_t ALU_AND  = 5'b00101;
  localparam alucode_t ALU_OR   = 5'b00110;
  localparam alucode_t ALU_SHR  = 5'b00111;
  localparam alucode_t ALU_SHRA = 5'b01000;
  localparam alucode_t ALU_SHL  = 5'b01001;
  localparam alucode_t ALU_ROR  = 5'b01010;
  localparam alucode_t ALU_ROL  = 5'b01011;
  localparam alucode_t ALU_MUL  = 5'b01111;
  localparam alucode_t ALU_DIV  = 5'b10000;
  localparam alucode_t ALU_NEG  = 5'b10001;
  localparam alucode_t ALU_NOT  = 5'b10010;

  localparam word_t WORD_MIN = {1'b1, {(WORD_W-1){1'b0}}};

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result to Z.
// MUL/DIV datapaths exist only when DATAPATH_MULDIV_EN is defined.
import datapath_pkg::*;

module alu (
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic [CODE_W-1:0] ALUcode,
  output logic [Z_W-1:0]    result
);

  logic [4:0]     amt;
  logic [Z_W-1:0] rot_r;
  logic [Z_W-1:0] rot_l;

  assign amt   = B[4:0];
  assign rot_r = {A, A} >> amt;
  assign rot_l = {A, A} << amt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [Z_W-1:0]    prod;
  logic                     div_zero;
  logic                     div_ovf;
  logic        [WORD_W-1:0] dvs;
  logic signed [WORD_W-1:0] quo;
  logic signed [WORD_W-1:0] rem;
  logic        [Z_W-1:0]    div_res;

  // Signed 32x32 product, both operands sign-extended to 64 bits.
  assign prod = $signed(A) * $signed(B);

  // MIN / -1 is steered to MIN / 1, which yields the wrapped quotient
  // and a zero remainder without overflowing the divider.
  assign div_zero = (B == '0);
  assign div_ovf  = (A == WORD_MIN) && (B == '1);
  assign dvs      = (div_zero || div_ovf) ? word_t'(1) : B;
  assign quo      = $signed(A) / $signed(dvs);
  assign rem      = $signed(A) % $signed(dvs);
  assign div_res  = div_zero ? '0 : {rem, quo};
`endif

  // Operation select; non-mul/div results land in the low word only.
  always_comb begin
    result = '0;
    case (ALUcode)
      ALU_ADD:  result[WORD_W-1:0] = A + B;
      ALU_SUB:  result[WORD_W-1:0] = A - B;
      ALU_AND:  result[WORD_W-1:0] = A & B;
      ALU_OR:   result[WORD_W-1:0] = A | B;
      ALU_SHR:  result[WORD_W-1:0] = A >> amt;
      ALU_SHRA: result[WORD_W-1:0] = $signed(A) >>> amt;
      ALU_SHL:  result[WORD_W-1:0] = A << amt;
      ALU_ROR:  result[WORD_W-1:0] = rot_r[WORD_W-1:0];
      ALU_ROL:  result[WORD_W-1:0] = rot_l[Z_W-1:WORD_W];
`ifdef DATAPATH_MULDIV_EN
      ALU_MUL:  result = prod;
      ALU_DIV:  result = div_res;
`endif
      ALU_NEG:  result[WORD_W-1:0] = -B;
      ALU_NOT:  result[WORD_W-1:0] = ~B;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/data_path.sv
// Single-bus datapath: register file, HI/LO/PC/MDR/Y/Z, bus mux, ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier and divider.
import datapath_pkg::*;

module data_path (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_REGS-1:0] regIn,
  input  logic                HiIn,
  input  logic                LoIn,
  input  logic                ZIn,
  input  logic                PCIn,
  input  logic                MDRIn,
  input  logic                YIn,
  input  logic [NUM_REGS-1:0] regOut,
  input  logic                HiOut,
  input  logic                LoOut,
  input  logic                ZHiOut,
  input  logic                ZLoOut,
  input  logic                PCOut,
  input  logic                MDROut,
  input  logic [WORD_W-1:0]   Mdata,
  input  logic                MDRread,
  input  logic [CODE_W-1:0]   ALUcode,
  input  logic [WORD_W-1:0]   temp,
  input  logic                tempEnable,
  output logic [WORD_W-1:0]   BusMuxOut
);

  logic [WORD_W-1:0] r_q [NUM_REGS];
  logic [WORD_W-1:0] r_d [NUM_REGS];
  logic [WORD_W-1:0] hi_q, hi_d;
  logic [WORD_W-1:0] lo_q, lo_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic [Z_W-1:0]    z_q, z_d;

  logic [WORD_W-1:0] bus;
  logic              reg_hit;
  logic [Z_W-1:0]    alu_res;

  // Bus mux: injected value first, then lowest-numbered register, then
  // the special registers in fixed order; idle bus reads zero.
  always_comb begin
    bus     = '0;
    reg_hit = 1'b0;
    if (tempEnable) begin
      bus = temp;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!reg_hit && regOut[i]) begin
          bus     = r_q[i];
          reg_hit = 1'b1;
        end
      end
      if (!reg_hit) begin
        if (HiOut)       bus = hi_q;
        else if (LoOut)  bus = lo_q;
        else if (ZHiOut) bus = z_q[Z_W-1:WORD_W];
        else if (ZLoOut) bus = z_q[WORD_W-1:0];
        else if (PCOut)  bus = pc_q;
        else if (MDROut) bus = mdr_q;
      end
    end
  end

  assign BusMuxOut = bus;

  alu u_alu (
    .A       (y_q),
    .B       (bus),
    .ALUcode (ALUcode),
    .result  (alu_res)
  );

  // Next-state: each register takes the bus when strobed, MDR may
  // take memory data instead, Z takes the ALU result.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      r_d[i] = regIn[i] ? bus : r_q[i];
    end
    hi_d  = HiIn ? bus : hi_q;
    lo_d  = LoIn ? bus : lo_q;
    pc_d  = PCIn ? bus : pc_q;
    y_d   = YIn  ? bus : y_q;
    z_d   = ZIn  ? alu_res : z_q;
    mdr_d = mdr_q;
    if (MDRIn) begin
      mdr_d = MDRread ? Mdata : bus;
    end
  end

  // State registers with synchronous clear taking precedence.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_q[i] <= '0;
      end
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_q[i] <= r_d[i];
      end
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus random
// ALU and register-transfer traffic against a behavioural model.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] regIn;
  logic        HiIn, LoIn, ZIn, PCIn, MDRIn, YIn;
  logic [15:0] regOut;
  logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut;
  logic [31:0] Mdata;
  logic        MDRread;
  logic [4:0]  ALUcode;
  logic [31:0] temp;
  logic        tempEnable;
  logic [31:0] BusMuxOut;

  int checks   = 0;
  int failures = 0;

  localparam int S_HI  = 16;
  localparam int S_LO  = 17;
  localparam int S_ZHI = 18;
  localparam int S_ZLO = 19;
  localparam int S_PC  = 20;
  localparam int S_MDR = 21;
  localparam int S_Y   = 22;
  localparam int S_Z   = 23;

  data_path dut (
    .clock      (clock),
    .clear      (clear),
    .regIn      (regIn),
    .HiIn       (HiIn),
    .LoIn       (LoIn),
    .ZIn        (ZIn),
    .PCIn       (PCIn),
    .MDRIn      (MDRIn),
    .YIn        (YIn),
    .regOut     (regOut),
    .HiOut      (HiOut),
    .LoOut      (LoOut),
    .ZHiOut     (ZHiOut),
    .ZLoOut     (ZLoOut),
    .PCOut      (PCOut),
    .MDROut     (MDROut),
    .Mdata      (Mdata),
    .MDRread    (MDRread),
    .ALUcode    (ALUcode),
    .temp       (temp),
    .tempEnable (tempEnable),
    .BusMuxOut  (BusMuxOut)
  );

  always #5 clock = ~clock;

  // Reference ALU from the operation definitions, shifts done bit by bit.
  function automatic logic [63:0] ref_alu(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [4:0]  code);
    int          s;
    logic [31:0] x;
    longint      p, q, r;
    s = int'(b[4:0]);
    x = a;
    p = 0; q = 0; r = 0;
    case (code)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  begin
        for (int i = 0; i < s; i++) x = x / 2;
        return {32'h0, x};
      end
      5'd8:  begin
        for (int i = 0; i < s; i++) x = {x[31], x[31:1]};
        return {32'h0, x};
      end
      5'd9:  begin
        for (int i = 0; i < s; i++) x = x * 2;
        return {32'h0, x};
      end
      5'd10: begin
        for (int i = 0; i < s; i++) x = {x[0], x[31:1]};
        return {32'h0, x};
      end
      5'd11: begin
        for (int i = 0; i < s; i++) x = {x[30:0], x[31]};
        return {32'h0, x};
      end
`ifdef DATAPATH_MULDIV_EN
      5'd15: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      5'd16: begin
        if (b == 0) return 64'h0;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
      end
`endif
      5'd17: return {32'h0, 32'h0 - b};
      5'd18: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic idle();
    clear = 0; regIn = '0; regOut = '0;
    HiIn = 0; LoIn = 0; ZIn = 0; PCIn = 0; MDRIn = 0; YIn = 0;
    HiOut = 0; LoOut = 0; ZHiOut = 0; ZLoOut = 0; PCOut = 0; MDROut = 0;
    Mdata = '0; MDRread = 0; ALUcode = '0; temp = '0; tempEnable = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int s);
    if (s < 16) regIn[s] = 1'b1;
    else case (s)
      S_HI:  HiIn  = 1;
      S_LO:  LoIn  = 1;
      S_PC:  PCIn  = 1;
      S_MDR: MDRIn = 1;
      S_Y:   YIn   = 1;
      S_Z:   ZIn   = 1;
      default: ;
    endcase
  endtask

  task automatic set_out(input int s);
    if (s < 16) regOut[s] = 1'b1;
    else case (s)
      S_HI:  HiOut  = 1;
      S_LO:  LoOut  = 1;
      S_ZHI: ZHiOut = 1;
      S_ZLO: ZLoOut = 1;
      S_PC:  PCOut  = 1;
      S_MDR: MDROut = 1;
      default: ;
    endcase
  endtask

  task automatic put(input int s, input logic [31:0] v);
    idle();
    temp = v; tempEnable = 1; set_in(s);
    tick();
    idle();
  endtask

  task automatic rd(input int s, output logic [31:0] v);
    idle();
    set_out(s);
    #1;
    v = BusMuxOut;
    idle();
  endtask

  task automatic run_alu(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] code);
    put(S_Y, a);
    temp = b; tempEnable = 1; ALUcode = code; ZIn = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) put(i, 32'hA5000000 | i);
    put(S_HI, 32'h11); put(S_LO, 32'h22); put(S_PC, 32'h33);
    put(S_MDR, 32'h44);
    run_alu(32'h55, 32'h1, 5'd3);
    put(S_Y, 32'h66);
    idle();
    clear = 1; regOut[3] = 1;
    #1;
    checks++;
    if (BusMuxOut !== 32'hA5000003) begin
      failures++;
      $display("FAIL bus_during_clear got=%h exp=%h", BusMuxOut, 32'hA5000003);
    end
    tick();
    idle();
    #1;
    checks++;
    if (BusMuxOut !== 32'h0) begin
      failures++;
      $display("FAIL idle_bus got=%h exp=0", BusMuxOut);
    end
    for (int i = 0; i < 22; i++) begin
      rd(i, v);
      checks++;
      if (v !== 32'h0) begin
        failures++;
        $display("FAIL reset_sel%0d got=%h exp=0", i, v);
      end
    end
    temp = 32'h0; tempEnable = 1; ALUcode = 5'd3; ZIn = 1;
    tick();
    rd(S_ZLO, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL reset_y got=%h exp=0", v);
    end
  endtask

  task automatic test_add();
    logic [31:0] v;
    put(3, 32'd555);
    put(7, -32'sd666);
    regOut[3] = 1; YIn = 1; tick(); idle();
    regOut[7] = 1; ALUcode = 5'b00011; ZIn = 1; tick(); idle();
    ZLoOut = 1; regIn[4] = 1; tick(); idle();
    rd(4, v);
    checks++;
    if (v !== 32'hFFFFFF91) begin
      failures++;
      $display("FAIL add_r4 got=%h exp=ffffff91", v);
    end
    rd(S_ZHI, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL add_zhi got=%h exp=0", v);
    end
  endtask

  task automatic test_mdr();
    logic [31:0] v;
    Mdata = 32'h1A1B8000; MDRread = 1; MDRIn = 1;
    temp = 32'hDEADBEEF; tempEnable = 1;
    tick(); idle();
    rd(S_MDR, v);
    checks++;
    if (v !== 32'h1A1B8000) begin
      failures++;
      $display("FAIL mdr_mem got=%h exp=1a1b8000", v);
    end
    MDROut = 1; PCIn = 1; tick(); idle();
    rd(S_PC, v);
    checks++;
    if (v !== 32'h1A1B8000) begin
      failures++;
      $display("FAIL pc_from_mdr got=%h exp=1a1b8000", v);
    end
    Mdata = 32'hFFFF0000; MDRread = 0; MDRIn = 1;
    temp = 32'h12345678; tempEnable = 1;
    tick(); idle();
    rd(S_MDR, v);
    checks++;
    if (v !== 32'h12345678) begin
      failures++;
      $display("FAIL mdr_bus got=%h exp=12345678", v);
    end
  endtask

  task automatic test_muldiv();
    logic [31:0] v;
    logic [63:0] e;
`ifdef DATAPATH_MULDIV_EN
    e = 64'hFFFFFFFE_80000003;
`else
    e = 64'h0;
`endif
    run_alu(-32'sd3, 32'h7FFFFFFF, 5'b01111);
    ZHiOut = 1; HiIn = 1; tick(); idle();
    ZLoOut = 1; LoIn = 1; tick(); idle();
    rd(S_HI, v);
    checks++;
    if (v !== e[63:32]) begin
      failures++;
      $display("FAIL mul_hi got=%h exp=%h", v, e[63:32]);
    end
    rd(S_LO, v);
    checks++;
    if (v !== e[31:0]) begin
      failures++;
      $display("FAIL mul_lo got=%h exp=%h", v, e[31:0]);
    end
`ifdef DATAPATH_MULDIV_EN
    e = {32'hFFFFFFFF, 32'hFFFFFFFD};
`else
    e = 64'h0;
`endif
    run_alu(-32'sd7, 32'd2, 5'b10000);
    rd(S_ZLO, v);
    checks++;
    if (v !== e[31:0]) begin
      failures++;
      $display("FAIL div_quo got=%h exp=%h", v, e[31:0]);
    end
    rd(S_ZHI, v);
    checks++;
    if (v !== e[63:32]) begin
      failures++;
      $display("FAIL div_rem got=%h exp=%h", v, e[63:32]);
    end
    run_alu(32'd100, 32'd0, 5'b10000);
    rd(S_ZLO, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL div0_lo got=%h exp=0", v);
    end
    rd(S_ZHI, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL div0_hi got=%h exp=0", v);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] v;
    logic [4:0]  codes [5];
    logic [31:0] exps  [5];
    codes = '{5'b01000, 5'b01011, 5'b00111, 5'b01001, 5'b01010};
    exps  = '{32'hC0000000, 32'h00000003, 32'h40000000,
              32'h00000002, 32'hC0000000};
    for (int i = 0; i < 5; i++) begin
      run_alu(32'h80000001, 32'd1, codes[i]);
      rd(S_ZLO, v);
      checks++;
      if (v !== exps[i]) begin
        failures++;
        $display("FAIL shift_code%0d got=%h exp=%h", codes[i], v, exps[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    put(2, 32'h22222222);
    put(9, 32'h99999999);
    put(S_HI, 32'h0000AAAA);
    put(S_LO, 32'h0000BBBB);
    put(S_PC, 32'h0000CCCC);
    temp = 32'h7E7E7E7E; tempEnable = 1; regOut[2] = 1;
    #1;
    checks++;
    if (BusMuxOut !== 32'h7E7E7E7E) begin
      failures++;
      $display("FAIL prio_temp got=%h exp=7e7e7e7e", BusMuxOut);
    end
    idle();
    regOut[9] = 1; regOut[2] = 1; HiOut = 1;
    #1;
    checks++;
    if (BusMuxOut !== 32'h22222222) begin
      failures++;
      $display("FAIL prio_reg got=%h exp=22222222", BusMuxOut);
    end
    idle();
    LoOut = 1; HiOut = 1; PCOut = 1;
    #1;
    checks++;
    if (BusMuxOut !== 32'h0000AAAA) begin
      failures++;
      $display("FAIL prio_hi got=%h exp=0000aaaa", BusMuxOut);
    end
    idle();
    PCOut = 1; MDROut = 1;
    #1;
    checks++;
    if (BusMuxOut !== 32'h0000CCCC) begin
      failures++;
      $display("FAIL prio_pc got=%h exp=0000cccc", BusMuxOut);
    end
    idle();
    put(5, 32'h55555555);
    clear = 1; regIn[5] = 1; temp = 32'h12121212; tempEnable = 1;
    tick(); idle();
    rd(5, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL clear_over_load got=%h exp=0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    put(6, 32'h600D600D);
    regOut[6] = 1; regIn[6] = 1; tick(); idle();
    rd(6, v);
    checks++;
    if (v !== 32'h600D600D) begin
      failures++;
      $display("FAIL self_reload got=%h exp=600d600d", v);
    end
    regOut[6] = 1; regIn[8] = 1; tick(); idle();
    regOut[8] = 1; regIn[9] = 1; tick(); idle();
    rd(9, v);
    checks++;
    if (v !== 32'h600D600D) begin
      failures++;
      $display("FAIL chain_r9 got=%h exp=600d600d", v);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b, lo, hi;
    logic [63:0] e;
    logic [4:0]  code;
    logic [4:0]  pool [18];
    pool = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
             5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd2, 5'd12, 5'd19, 5'd31};
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = $urandom_range(0, 40);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      code = pool[$urandom_range(0, 17)];
      e = ref_alu(a, b, code);
      run_alu(a, b, code);
      rd(S_ZLO, lo);
      rd(S_ZHI, hi);
      checks++;
      if ({hi, lo} !== e) begin
        failures++;
        $display("FAIL rand_alu code=%0d a=%h b=%h got=%h exp=%h",
                 code, a, b, {hi, lo}, e);
      end
    end
  endtask

  task automatic test_random_xfer();
    logic [31:0] m [16];
    logic [31:0] v;
    int          src, dst, pick;
    for (int i = 0; i < 16; i++) begin
      m[i] = $urandom;
      put(i, m[i]);
    end
    for (int n = 0; n < 100; n++) begin
      src = $urandom_range(0, 15);
      dst = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        m[dst] = $urandom;
        put(dst, m[dst]);
      end else begin
        regOut[src] = 1; regIn[dst] = 1; tick(); idle();
        m[dst] = m[src];
      end
      pick = $urandom_range(0, 15);
      rd(pick, v);
      checks++;
      if (v !== m[pick]) begin
        failures++;
        $display("FAIL rand_xfer r%0d got=%h exp=%h", pick, v, m[pick]);
      end
    end
  endtask

  initial begin
    idle();
    clear = 1;
    tick();
    idle();
    test_reset();
    test_add();
    test_mdr();
    test_muldiv();
    test_shifts();
    test_priority();
    test_back_to_back();
    test_random_alu();
    test_random_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
